// File: rtl/regfile_commit_ctrl.sv
// ============================================================================
// Module      : regfile_commit_ctrl
// Description : Buffers ROB commit results in an in-order FIFO and drains one
//               per cycle onto the single RegFile write port. r0 commits are
//               dropped and draining can be stalled with hold.
//               Optional macro COMMIT_BYPASS_EN: an empty FIFO forwards a
//               commit straight to the write port (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_commit_ctrl #(
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_W-1:0]           in_name,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ENTRY_W-1:0]         in_entry,
    input  logic                       hold,
    output logic                       ROB_we,
    output logic [REG_W-1:0]           namew,
    output logic [DATA_W-1:0]          dataw,
    output logic [ENTRY_W-1:0]         entryw,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WORD_W = REG_W + DATA_W + ENTRY_W;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [c_WORD_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                r_rob_we;
    logic [REG_W-1:0]    r_namew;
    logic [DATA_W-1:0]   r_dataw;
    logic [ENTRY_W-1:0]  r_entryw;

    logic                w_push;
    logic                w_store;
    logic                w_pop;
    logic                w_bypass;
    logic                w_wr;
    logic [c_WORD_W-1:0] w_in_word;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_CNT);
    assign in_ready  = !full;
    assign count     = r_count;

    assign w_push    = in_valid && in_ready;
    // r0 writes complete the handshake but never occupy a slot.
    assign w_store   = w_push && (in_name != '0);
    assign w_pop     = !empty && !hold;
    assign w_in_word = {in_name, in_data, in_entry};

`ifdef COMMIT_BYPASS_EN
    assign w_bypass  = empty && w_store && !hold;
`else
    assign w_bypass  = 1'b0;
`endif

    assign w_wr      = w_store && !w_bypass;

    // Storage is intentionally left unreset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rob_we <= 1'b0;
            r_namew  <= '0;
            r_dataw  <= '0;
            r_entryw <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Pop and bypass are exclusive: bypass requires an empty FIFO.
            r_rob_we <= w_pop || w_bypass;
            if (w_pop) begin
                {r_namew, r_dataw, r_entryw} <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                {r_namew, r_dataw, r_entryw} <= w_in_word;
            end
        end
    end

    assign ROB_we = r_rob_we;
    assign namew  = r_namew;
    assign dataw  = r_dataw;
    assign entryw = r_entryw;

endmodule

`default_nettype wire

// File: tb/tb_regfile_commit_ctrl.sv
// ============================================================================
// Module      : tb_regfile_commit_ctrl
// Description : Directed self-checking bench for regfile_commit_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_commit_ctrl;

`ifdef COMMIT_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_name;
    logic [31:0] in_data;
    logic [2:0]  in_entry;
    logic        hold;
    logic        ROB_we;
    logic [4:0]  namew;
    logic [31:0] dataw;
    logic [2:0]  entryw;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [39:0] wr_log[$];
    int          max_cnt = 0;

    always #5 clk = ~clk;

    regfile_commit_ctrl #(
        .REG_W   (5),
        .DATA_W  (32),
        .ENTRY_W (3),
        .DEPTH   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_name  (in_name),
        .in_data  (in_data),
        .in_entry (in_entry),
        .hold     (hold),
        .ROB_we   (ROB_we),
        .namew    (namew),
        .dataw    (dataw),
        .entryw   (entryw),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    // Record every RegFile write and the peak occupancy, mid-cycle.
    always @(negedge clk) begin
        if (ROB_we) wr_log.push_back({namew, dataw, entryw});
        if (int'(count) > max_cnt) max_cnt = int'(count);
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] n, input logic [31:0] d, input logic [2:0] e);
        in_valid = 1'b1;
        in_name  = n;
        in_data  = d;
        in_entry = e;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_name  = '0;
        in_data  = '0;
        in_entry = '0;
        hold     = 1'b0;

        // Reset
        tick();
        tick();
        chk_val("rst_we",    64'(ROB_we),   64'd0);
        chk_val("rst_count", 64'(count),    64'd0);
        chk_val("rst_empty", 64'(empty),    64'd1);
        chk_val("rst_ready", 64'(in_ready), 64'd1);
        chk_val("rst_full",  64'(full),     64'd0);
        chk_val("rst_namew", 64'(namew),    64'd0);
        chk_val("rst_dataw", 64'(dataw),    64'd0);
        chk_val("rst_entry", 64'(entryw),   64'd0);
        rst = 1'b1;
        tick();

        // Single commit
        wr_log.delete();
        push(5'd5, 32'hDEADBEEF, 3'd3);
        if (!c_BYPASS) begin
            chk_val("single_t_we",    64'(ROB_we), 64'd0);
            chk_val("single_t_count", 64'(count),  64'd1);
            tick();
        end
        chk_val("single_we",    64'(ROB_we), 64'd1);
        chk_val("single_name",  64'(namew),  64'd5);
        chk_val("single_data",  64'(dataw),  64'hDEADBEEF);
        chk_val("single_entry", 64'(entryw), 64'd3);
        chk_val("single_count", 64'(count),  64'd0);
        tick();
        chk_val("single_we_off", 64'(ROB_we), 64'd0);
        chk_val("single_nwr",    64'(wr_log.size()), 64'd1);

        // Fill under hold, then drain
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i), 3'(i));
        chk_val("fill_full",  64'(full),     64'd1);
        chk_val("fill_ready", 64'(in_ready), 64'd0);
        chk_val("fill_count", 64'(count),    64'd4);
        chk_val("fill_we",    64'(ROB_we),   64'd0);
        push(5'd9, 32'h999, 3'd1);
        chk_val("fill_5th_count", 64'(count), 64'd4);
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_val("drain_we",   64'(ROB_we), 64'd1);
            chk_val("drain_name", 64'(namew),  64'(i));
            chk_val("drain_data", 64'(dataw),  64'h100 + 64'(i));
        end
        tick();
        chk_val("drain_we_off", 64'(ROB_we), 64'd0);
        chk_val("drain_empty",  64'(empty),  64'd1);

        // r0 filter
        wr_log.delete();
        max_cnt = 0;
        push(5'd0, 32'hAAAA, 3'd2);
        chk_val("r0_count", 64'(count), 64'd0);
        push(5'd7, 32'h7777, 3'd4);
        tick();
        tick();
        tick();
        chk_val("r0_nwr",  64'(wr_log.size()), 64'd1);
        chk_val("r0_word", (wr_log.size() > 0) ? 64'(wr_log[0]) : 64'd0,
                64'({5'd7, 32'h7777, 3'd4}));
        chk_val("r0_peak", 64'(max_cnt), c_BYPASS ? 64'd0 : 64'd1);

        // Continuous stream with pointer wrap
        wr_log.delete();
        max_cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_name  = 5'(i + 1);
            in_data  = 32'h1000_0000 + 32'(i);
            in_entry = 3'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk_val("wrap_nwr",  64'(wr_log.size()), 64'd10);
        chk_val("wrap_peak", 64'(max_cnt), c_BYPASS ? 64'd0 : 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk_val("wrap_order", (i < wr_log.size()) ? 64'(wr_log[i]) : 64'd0,
                    64'({5'(i + 1), 32'h1000_0000 + 32'(i), 3'(i)}));
        end

        // Reset while holding buffered commits
        hold = 1'b1;
        push(5'd11, 32'hB0B, 3'd1);
        push(5'd12, 32'hC0C, 3'd2);
        push(5'd13, 32'hD0D, 3'd3);
        chk_val("mid_count_pre", 64'(count), 64'd3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_val("mid_count", 64'(count),  64'd0);
        chk_val("mid_we",    64'(ROB_we), 64'd0);
        chk_val("mid_empty", 64'(empty),  64'd1);
        wr_log.delete();
        hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_val("mid_nwr", 64'(wr_log.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
